pll_lock_supervisor: RTL and testbench



---
 rtl/pll_sup_pkg.sv | 21 ++
 rtl/pll_sup_if.sv | 25 ++
 rtl/pll_sup_sync.sv | 24 ++
 rtl/pll_lock_supervisor.sv | 115 +++++++++++
 tb/tb_pll_lock_supervisor.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;

    // Supervisor phases; the 2-bit encoding is fixed so that debug taps
    // and status readers can decode the state directly.
    typedef enum logic [1:0] {
        S_PLL_RST   = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_RUN       = 2'd3
    } sup_state_e;

    // Width of the retry / relock statistics counters.
    localparam int COUNT_W = 8;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == {COUNT_W{1'b1}}) ? v : v + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/pll_sup_if.sv
// PLL-side and system-side signals of the lock supervisor.
// master = supervisor, slave = PLL wrapper / status consumer.
interface pll_sup_if;
    import pll_sup_pkg::*;

    logic               pll_locked;    // raw PLL lock, asynchronous to refclk
    logic               relock_req;    // one-cycle software relock request
    logic               pll_rst;       // PLL reset input
    logic               sys_rst;       // reset for PLL-clocked logic
    logic               lock_ok;       // lock qualified, system running
    logic               timeout_err;   // sticky lock timeout flag
    logic [COUNT_W-1:0] retry_count;   // saturating lock timeouts
    logic [COUNT_W-1:0] relock_count;  // saturating lock losses in run

    modport master (
        input  pll_locked, relock_req,
        output pll_rst, sys_rst, lock_ok, timeout_err, retry_count, relock_count
    );

    modport slave (
        output pll_locked, relock_req,
        input  pll_rst, sys_rst, lock_ok, timeout_err, retry_count, relock_count
    );

endinterface

// File: rtl/pll_sup_sync.sv
// Multi-flop synchronizer bringing the PLL lock flag into the refclk domain.
module pll_sup_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift chain; cleared so a stale lock cannot leak through a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, qualifies lock for a stable
// window, then releases the system reset. Retries on timeout, loss of lock
// or a software relock request. Single clock domain: the free-running refclk.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int SYNC_STAGES         = 2,
    parameter int CNT_W               = 16
) (
    input  logic      refclk,
    input  logic      rst,
    pll_sup_if.master sup
);

    // Terminal counts of each timed phase (counter runs 0..N-1).
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

    sup_state_e         state;
    logic [CNT_W-1:0]   cnt;
    logic               lk;
    logic               timeout_err_q;
    logic [COUNT_W-1:0] retry_q;
    logic [COUNT_W-1:0] relock_q;

    pll_sup_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (refclk),
        .rst (rst),
        .d   (sup.pll_locked),
        .q   (lk)
    );

    // Phase FSM with its phase counter and the lock statistics.
    // A relock request pre-empts every other transition except while the
    // PLL is already being reset, where it is dropped rather than stretching
    // the pulse. A lock loss that coincides with a request in S_RUN is still
    // a lock loss and is counted once.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state         <= S_PLL_RST;
            cnt           <= '0;
            timeout_err_q <= 1'b0;
            retry_q       <= '0;
            relock_q      <= '0;
        end else if (sup.relock_req && (state != S_PLL_RST)) begin
            if ((state == S_RUN) && !lk) begin
                relock_q <= sat_inc(relock_q);
            end
            state <= S_PLL_RST;
            cnt   <= '0;
        end else begin
            case (state)
                S_PLL_RST: begin
                    if (cnt == RST_LAST) begin
                        state <= S_WAIT_LOCK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (lk) begin
                        state <= S_STABLE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        timeout_err_q <= 1'b1;
                        retry_q       <= sat_inc(retry_q);
                        state         <= S_PLL_RST;
                        cnt           <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_STABLE: begin
                    // Any dropout restarts qualification with a fresh timeout.
                    if (!lk) begin
                        state <= S_WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state <= S_RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (!lk) begin
                        relock_q <= sat_inc(relock_q);
                        state    <= S_PLL_RST;
                    end
                    cnt <= '0;
                end
                default: begin
                    state <= S_PLL_RST;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Moore outputs decoded straight from the state register.
    assign sup.pll_rst      = (state == S_PLL_RST);
    assign sup.sys_rst      = (state != S_RUN);
    assign sup.lock_ok      = (state == S_RUN);
    assign sup.timeout_err  = timeout_err_q;
    assign sup.retry_count  = retry_q;
    assign sup.relock_count = relock_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: checkpoint tables for the basic sequences,
// hand-written corner sequences, and a random run against a reference model.
module tb_pll_lock_supervisor;
    import pll_sup_pkg::*;

    localparam int RP = 4;
    localparam int TO = 32;
    localparam int ST = 8;
    localparam int SS = 2;

    localparam int PH_PULSE  = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_SETTLE = 2;
    localparam int PH_UP     = 3;

    logic refclk = 1'b0;
    logic rst;
    pll_sup_if bus ();

    always #5 refclk = ~refclk;

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES    (RP),
        .LOCK_TIMEOUT_CYCLES (TO),
        .LOCK_STABLE_CYCLES  (ST),
        .SYNC_STAGES         (SS),
        .CNT_W               (16)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .sup    (bus.master)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %b want %b", nm, cyc, act, exp);
        end
    endtask

    task automatic chkn(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0d want %0d", nm, cyc, act, exp);
        end
    endtask

    // Reference model: phase plus the cycle it was entered; lock seen through
    // a SYNC_STAGES-deep delay queue of sampled pll_locked values.
    int m_phase, m_entry, m_cyc;
    bit m_q[$];
    bit m_terr;
    int m_retry, m_relock;

    task automatic model_edge();
        if (rst) begin
            m_phase = PH_PULSE;
            m_entry = m_cyc + 1;
            m_q.delete();
            for (int i = 0; i < SS; i++) m_q.push_back(1'b0);
            m_terr   = 1'b0;
            m_retry  = 0;
            m_relock = 0;
        end else begin
            int age;
            bit lk;
            int nxt;
            age = m_cyc - m_entry;
            lk  = m_q[0];
            nxt = m_phase;
            if (m_phase == PH_UP && !lk) begin
                m_relock = (m_relock < 255) ? m_relock + 1 : 255;
                nxt = PH_PULSE;
            end
            if (bus.relock_req && m_phase != PH_PULSE) begin
                nxt = PH_PULSE;
            end else if (m_phase == PH_PULSE) begin
                if (age == RP - 1) nxt = PH_WAIT;
            end else if (m_phase == PH_WAIT) begin
                if (lk) nxt = PH_SETTLE;
                else if (age == TO - 1) begin
                    m_terr  = 1'b1;
                    m_retry = (m_retry < 255) ? m_retry + 1 : 255;
                    nxt = PH_PULSE;
                end
            end else if (m_phase == PH_SETTLE) begin
                if (!lk) nxt = PH_WAIT;
                else if (age == ST - 1) nxt = PH_UP;
            end
            if (nxt != m_phase) m_entry = m_cyc + 1;
            m_phase = nxt;
            void'(m_q.pop_front());
            m_q.push_back(bus.pll_locked);
        end
        m_cyc++;
    endtask

    task automatic check_model();
        chk1("m_pll_rst", bus.pll_rst, m_phase == PH_PULSE);
        chk1("m_sys_rst", bus.sys_rst, m_phase != PH_UP);
        chk1("m_lock_ok", bus.lock_ok, m_phase == PH_UP);
        chk1("m_timeout_err", bus.timeout_err, m_terr);
        chkn("m_retry_count", int'(bus.retry_count), m_retry);
        chkn("m_relock_count", int'(bus.relock_count), m_relock);
    endtask

    task automatic step();
        @(posedge refclk);
        model_edge();
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    // Three reset cycles; afterwards cyc==0 is the first cycle with rst low.
    task automatic do_reset();
        bus.pll_locked = 1'b0;
        bus.relock_req = 1'b0;
        rst = 1'b1;
        step();
        chk1("rst_pll_rst", bus.pll_rst, 1'b1);
        chk1("rst_sys_rst", bus.sys_rst, 1'b1);
        chk1("rst_lock_ok", bus.lock_ok, 1'b0);
        step();
        step();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic expect_out(input string nm, input logic prst, input logic srst, input logic ok);
        chk1({nm, "_pll_rst"}, bus.pll_rst, prst);
        chk1({nm, "_sys_rst"}, bus.sys_rst, srst);
        chk1({nm, "_lock_ok"}, bus.lock_ok, ok);
    endtask

    // Checkpoint record: expected outputs at cycle cyc, then pll_locked is
    // driven to 'locked' (first sampled at the edge ending that cycle).
    typedef struct {
        int cyc;
        bit locked;
        bit e_prst;
        bit e_srst;
        bit e_ok;
        bit e_terr;
        int e_retry;
    } vec_t;

    function automatic vec_t mk(int c, bit l, bit p, bit s, bit o, bit t, int r);
        vec_t v;
        v.cyc = c; v.locked = l; v.e_prst = p; v.e_srst = s;
        v.e_ok = o; v.e_terr = t; v.e_retry = r;
        return v;
    endfunction

    task automatic run_tab(input vec_t tab[$], input string tag);
        foreach (tab[i]) begin
            run_to(tab[i].cyc);
            expect_out(tag, tab[i].e_prst, tab[i].e_srst, tab[i].e_ok);
            chk1({tag, "_timeout_err"}, bus.timeout_err, tab[i].e_terr);
            chkn({tag, "_retry"}, int'(bus.retry_count), tab[i].e_retry);
            bus.pll_locked = tab[i].locked;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t t_nolock[$];
        vec_t t_clean[$];
        vec_t t_glitch[$];
        int hold;

        // No lock: retries every RP+TO cycles.
        t_nolock.push_back(mk(0,  0, 1, 1, 0, 0, 0));
        t_nolock.push_back(mk(3,  0, 1, 1, 0, 0, 0));
        t_nolock.push_back(mk(4,  0, 0, 1, 0, 0, 0));
        t_nolock.push_back(mk(35, 0, 0, 1, 0, 0, 0));
        t_nolock.push_back(mk(36, 0, 1, 1, 0, 1, 1));
        t_nolock.push_back(mk(39, 0, 1, 1, 0, 1, 1));
        t_nolock.push_back(mk(40, 0, 0, 1, 0, 1, 1));
        t_nolock.push_back(mk(72, 0, 1, 1, 0, 1, 2));

        // Clean lock sampled from edge 6 -> run at cycle 16.
        t_clean.push_back(mk(0,  0, 1, 1, 0, 0, 0));
        t_clean.push_back(mk(5,  1, 0, 1, 0, 0, 0));
        t_clean.push_back(mk(15, 1, 0, 1, 0, 0, 0));
        t_clean.push_back(mk(16, 1, 0, 0, 1, 0, 0));
        t_clean.push_back(mk(20, 1, 0, 0, 1, 0, 0));

        // Lock dropout sampled at edges 11-13 during qualification.
        t_glitch.push_back(mk(5,  1, 0, 1, 0, 0, 0));
        t_glitch.push_back(mk(10, 0, 0, 1, 0, 0, 0));
        t_glitch.push_back(mk(13, 1, 0, 1, 0, 0, 0));
        t_glitch.push_back(mk(16, 1, 0, 1, 0, 0, 0));
        t_glitch.push_back(mk(23, 1, 0, 1, 0, 0, 0));
        t_glitch.push_back(mk(24, 1, 0, 0, 1, 0, 0));

        do_reset();
        run_tab(t_nolock, "nolock");

        do_reset();
        run_tab(t_glitch, "glitch");
        chkn("glitch_relock", int'(bus.relock_count), 0);

        do_reset();
        run_tab(t_clean, "clean");

        // Single-cycle lock loss in run (sampled at edge 21).
        bus.pll_locked = 1'b0;
        step();
        bus.pll_locked = 1'b1;
        run_to(22); expect_out("loss_pre", 0, 0, 1);
        run_to(23); expect_out("loss", 1, 1, 0);
        chkn("loss_relock", int'(bus.relock_count), 1);
        run_to(26); expect_out("loss_pulse_end", 1, 1, 0);
        run_to(27); expect_out("loss_wait", 0, 1, 0);
        run_to(35); expect_out("loss_stable", 0, 1, 0);
        run_to(36); expect_out("loss_rerun", 0, 0, 1);
        chkn("loss_retry", int'(bus.retry_count), 0);

        // Relock request coinciding with the FSM seeing lock loss.
        run_to(40);
        bus.pll_locked = 1'b0;
        step();
        bus.pll_locked = 1'b1;
        run_to(42);
        bus.relock_req = 1'b1;
        step();
        bus.relock_req = 1'b0;
        expect_out("simul", 1, 1, 0);
        chkn("simul_relock", int'(bus.relock_count), 2);
        // Request during the PLL reset pulse must not stretch it.
        run_to(44);
        bus.relock_req = 1'b1;
        step();
        bus.relock_req = 1'b0;
        run_to(46); expect_out("inpulse_last", 1, 1, 0);
        run_to(47); expect_out("inpulse_wait", 0, 1, 0);
        chkn("inpulse_relock", int'(bus.relock_count), 2);
        run_to(56); expect_out("simul_rerun", 0, 0, 1);

        // Plain software relock in run: no count change.
        run_to(60);
        bus.relock_req = 1'b1;
        step();
        bus.relock_req = 1'b0;
        expect_out("swreq", 1, 1, 0);
        chkn("swreq_relock", int'(bus.relock_count), 2);
        run_to(65); expect_out("swreq_wait", 0, 1, 0);
        run_to(74); expect_out("swreq_rerun", 0, 0, 1);

        // Timeout saturation, tracked against the model throughout.
        do_reset();
        while (cyc < 10801) begin
            step();
            check_model();
            if (cyc == 9179) chkn("sat_254", int'(bus.retry_count), 254);
            if (cyc == 9180) chkn("sat_255", int'(bus.retry_count), 255);
        end
        chkn("sat_hold", int'(bus.retry_count), 255);
        chk1("sat_terr", bus.timeout_err, 1'b1);

        // Reset asserted while qualifying lock.
        bus.pll_locked = 1'b1;
        run_to(10806);
        expect_out("midrst_stable", 0, 1, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_out("midrst", 1, 1, 0);
        chkn("midrst_retry", int'(bus.retry_count), 0);
        chkn("midrst_relock", int'(bus.relock_count), 0);
        chk1("midrst_terr", bus.timeout_err, 1'b0);

        // Random run against the model.
        do_reset();
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                bus.pll_locked = ($urandom_range(0, 2) != 0);
                hold = $urandom_range(1, 60);
            end else begin
                hold--;
            end
            bus.relock_req = ($urandom_range(0, 63) == 0);
            rst = ($urandom_range(0, 499) == 0);
            step();
            check_model();
        end
        rst = 1'b0;
        bus.relock_req = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
